// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA message loader and encrypt engine handshake.
package sha_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PACK,
      PAD,
      ZERO,
      LEN_HI,
      LEN_LO,
      START,
      WAIT
   } state_t;

   localparam int         WORDS_PER_BLOCK = 16;
   localparam logic [7:0] PAD_BYTE        = 8'h80;
   localparam logic [1:0] START_HASH      = 2'b01;
   localparam logic [1:0] START_IDLE      = 2'b00;
   localparam int         STOP_DONE       = 0;

   // Message length in bits as stored in the final word of the padded message.
   function automatic logic [31:0] bit_length(input logic [10:0] bytes);
      return {18'b0, bytes, 3'b000};
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler; also presents the partial word closed with the pad byte.
module byte_packer
   import sha_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_done,
   output logic [31:0] pad_word
);

   logic [31:0] acc;
   logic [1:0]  lane;
   logic [4:0]  shift;

   // Lane 0 lands in bits [31:24], lane 3 in bits [7:0].
   assign shift     = {~lane, 3'b000};
   assign word      = acc | ({24'b0, data} << shift);
   assign pad_word  = acc | ({24'b0, PAD_BYTE} << shift);
   assign word_done = load && (lane == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         lane <= '0;
      end else if (clear) begin
         acc  <= '0;
         lane <= '0;
      end else if (load) begin
         acc  <= (lane == 2'd3) ? 32'h0 : word;
         lane <= lane + 2'd1;
      end
   end

endmodule

// File: rtl/sha_msg_loader.sv
// Packs a byte stream into the data BRAM, appends SHA padding and the bit length,
// then launches the encrypt engine and waits for its done flag.
module sha_msg_loader
   import sha_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int MAX_BLOCKS = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_we,
   output logic [8:0]        length,
   output logic [1:0]        start,
   input  logic [2:0]        stop,
   output logic              busy,
   output logic              err
);

   // Largest message that still leaves room for the 0x80 byte and 8 length bytes.
   localparam int LIMIT = WORDS_PER_BLOCK * MAX_BLOCKS * 4 - 9;

   state_t            state;
   state_t            state_d;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_inc;
   logic [10:0]       cnt;
   logic              take;
   logic              ovf;
   logic              at_len;
   logic [31:0]       pk_word;
   logic              pk_done;
   logic [31:0]       pk_pad;
   logic              stop_unused;

   assign take        = s_valid && s_ready;
   assign ovf         = take && (({1'b0, cnt} + 12'd1) > 12'(LIMIT));
   assign idx_inc     = idx + 1'b1;
   assign at_len      = (idx_inc[3:0] == 4'(WORDS_PER_BLOCK - 2));
   assign stop_unused = ^stop[2:1];

   byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (state != PACK),
      .load      (take),
      .data      (s_data),
      .word      (pk_word),
      .word_done (pk_done),
      .pad_word  (pk_pad)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = PACK;
         PACK:    if (take && s_last) state_d = (err || ovf) ? IDLE : PAD;
         PAD,
         ZERO:    state_d = at_len ? LEN_HI : ZERO;
         LEN_HI:  state_d = LEN_LO;
         LEN_LO:  state_d = START;
         START:   state_d = WAIT;
         WAIT:    if (stop[STOP_DONE]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_ready  <= 1'b0;
         busy     <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         length   <= '0;
         start    <= START_IDLE;
         err      <= 1'b0;
         idx      <= '0;
         cnt      <= '0;
      end else begin
         s_ready <= (state_d == PACK);
         busy    <= (state_d != IDLE);
         mem_we  <= 1'b0;
         case (state)
            IDLE: begin
               idx <= '0;
               cnt <= '0;
            end
            PACK: begin
               if (take) begin
                  cnt <= cnt + 11'd1;
                  if (ovf) err <= 1'b1;
                  // Once overflowed, the rest of the stream is drained without writes.
                  if (pk_done && !err && !ovf) begin
                     mem_we   <= 1'b1;
                     mem_addr <= idx;
                     mem_din  <= pk_word;
                     idx      <= idx_inc;
                  end
               end
            end
            PAD: begin
               mem_we   <= 1'b1;
               mem_addr <= idx;
               mem_din  <= pk_pad;
               idx      <= idx_inc;
            end
            ZERO, LEN_HI: begin
               mem_we   <= 1'b1;
               mem_addr <= idx;
               mem_din  <= 32'h0;
               idx      <= idx_inc;
            end
            LEN_LO: begin
               mem_we   <= 1'b1;
               mem_addr <= idx;
               mem_din  <= bit_length(cnt);
            end
            START: begin
               length <= 9'(idx_inc);
               start  <= START_HASH;
            end
            WAIT: begin
               if (stop[STOP_DONE]) start <= START_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha_msg_loader.sv
// Randomized bench for sha_msg_loader against a byte-level SHA padding model.
module tb_sha_msg_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [8:0]  mem_addr;
   logic [31:0] mem_din;
   logic        mem_we;
   logic [8:0]  length;
   logic [1:0]  start;
   logic [2:0]  stop;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   sha_msg_loader dut (
      .clk      (clk),
      .reset    (reset),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_we   (mem_we),
      .length   (length),
      .start    (start),
      .stop     (stop),
      .busy     (busy),
      .err      (err)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] mem [0:511];
   logic [31:0] img_abc [0:15];
   int          wr_cnt = 0;
   int          overlap = 0;
   bit          start_seen = 0;
   int          first_start = 0;
   logic [7:0]  msg [$];
   logic [31:0] exp_words [$];
   int          exp_len;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model and bus observer, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         mem[mem_addr] = mem_din;
         wr_cnt++;
      end
      if (mem_we && start != 2'b00) overlap++;
      if (start == 2'b01 && !start_seen) begin
         start_seen  = 1;
         first_start = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5A5A5;
      wr_cnt     = 0;
      start_seen = 0;
   endtask

   // Padded message: bytes, 0x80, zeros to 56 mod 64, then 64-bit big-endian bit count.
   task automatic build_model();
      logic [7:0]  p [$];
      logic [63:0] bits;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      exp_words.delete();
      for (int w = 0; w < p.size() / 4; w++)
         exp_words.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
      exp_len = p.size() / 4;
   endtask

   task automatic send(input int gap_pct, output int acc_cyc, output bit ok);
      int  i;
      int  guard;
      bit  accept;
      i     = 0;
      guard = 0;
      while (i < msg.size() && guard < 20000) begin
         if ($urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
         end else begin
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
         end
         accept = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (accept) i++;
         guard++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      acc_cyc = cyc;
      ok      = (i == msg.size());
   endtask

   task automatic run_msg(input string tag, input int gap_pct);
      int acc_cyc;
      bit ok;
      int n;
      int bad;
      clear_mon();
      build_model();
      send(gap_pct, acc_cyc, ok);
      chk({tag, "_sent"}, 64'(ok), 64'd1);
      n = 0;
      while (!start_seen && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_start_seen"}, 64'(start_seen), 64'd1);
      if (start_seen)
         chk({tag, "_latency"}, 64'(first_start - acc_cyc),
             64'(exp_len - msg.size() / 4 + 1));
      @(negedge clk);
      chk({tag, "_length"}, 64'(length), 64'(exp_len));
      chk({tag, "_start"}, 64'(start), 64'd1);
      chk({tag, "_busy_ready"}, {62'b0, busy, s_ready}, 64'd2);
      chk({tag, "_wr_count"}, 64'(wr_cnt), 64'(exp_len));
      bad = 0;
      for (int w = 0; w < exp_len; w++)
         if (mem[w] !== exp_words[w]) bad++;
      chk({tag, "_image_bad_words"}, 64'(bad), 64'd0);
      @(posedge clk);
      #1 stop = 3'b001;
      @(posedge clk);
      #1 stop = 3'b000;
      chk({tag, "_start_cleared"}, 64'(start), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_length_held"}, 64'(length), 64'(exp_len));
   endtask

   task automatic rand_msg(input int n);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, {58'b0, s_ready, mem_we, start, busy, err}, 64'd0);
      chk({tag, "_addr_din"}, {23'b0, mem_addr, mem_din}, 64'd0);
      chk({tag, "_length"}, 64'(length), 64'd0);
   endtask

   initial begin
      int acc_cyc;
      bit ok;
      int bad;
      reset   = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
      stop    = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      reset = 1'b0;

      msg = '{8'h61, 8'h62, 8'h63};
      run_msg("abc", 0);
      chk("abc_w0", 64'(mem[0]), 64'h61626380);
      chk("abc_w1", 64'(mem[1]), 64'h0);
      chk("abc_w14", 64'(mem[14]), 64'h0);
      chk("abc_w15", 64'(mem[15]), 64'h18);
      for (int i = 0; i < 16; i++) img_abc[i] = mem[i];

      msg = '{8'h61, 8'h62, 8'h63, 8'h64};
      run_msg("abcd", 0);
      chk("abcd_w0", 64'(mem[0]), 64'h61626364);
      chk("abcd_w1", 64'(mem[1]), 64'h80000000);
      chk("abcd_w15", 64'(mem[15]), 64'h20);

      rand_msg(55);
      run_msg("len55", 0);
      chk("len55_length", 64'(length), 64'd16);
      chk("len55_w13_lsb", 64'(mem[13][7:0]), 64'h80);

      rand_msg(56);
      run_msg("len56", 0);
      chk("len56_length", 64'(length), 64'd32);
      chk("len56_w31", 64'(mem[31]), 64'h1C0);

      msg = '{8'h61, 8'h62, 8'h63};
      run_msg("abc_gaps", 50);
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== img_abc[i]) bad++;
      chk("abc_gaps_same_image", 64'(bad), 64'd0);

      for (int r = 0; r < 6; r++) begin
         rand_msg(int'($urandom_range(1, 200)));
         run_msg($sformatf("rand%0d", r), int'($urandom_range(0, 60)));
      end

      // Reset in the middle of a message.
      @(posedge clk);
      #1;
      s_valid = 1'b1; s_data = 8'h61; s_last = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset");
      @(posedge clk);
      #1 reset = 1'b0;
      msg = '{8'h61, 8'h62, 8'h63};
      run_msg("abc_after_reset", 0);
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== img_abc[i]) bad++;
      chk("abc_after_reset_same_image", 64'(bad), 64'd0);

      // Overflow: 1976 bytes, one past the limit.
      rand_msg(1976);
      clear_mon();
      send(0, acc_cyc, ok);
      chk("ovf_drained", 64'(ok), 64'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("ovf_err", 64'(err), 64'd1);
      chk("ovf_no_start", 64'(start_seen), 64'd0);
      chk("ovf_wr_count", 64'(wr_cnt), 64'd493);
      bad = 0;
      for (int w = 0; w < 493; w++)
         if (mem[w] !== {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}) bad++;
      chk("ovf_image_bad_words", 64'(bad), 64'd0);
      chk("ovf_back_to_pack", 64'(s_ready), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("ovf_err_cleared", 64'(err), 64'd0);
      reset = 1'b0;

      chk("we_start_overlap", 64'(overlap), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
